// File: rtl/fpu_issue_wrapper.sv
// Operand-capture FIFO and single-issue FSM in front of the multi-cycle FPU core.
// Define FPU_ISSUE_BYPASS_EN to let a request issue straight to the core when the stage is idle and empty.
module fpu_issue_wrapper #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic [2:0]       req_rm,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [XLEN-1:0]  req_c,
    input  logic [TAG_W-1:0] req_tag,
    output logic             core_start,
    output logic [OP_W-1:0]  core_op,
    output logic [2:0]       core_rm,
    output logic [XLEN-1:0]  core_a,
    output logic [XLEN-1:0]  core_b,
    output logic [XLEN-1:0]  core_c,
    input  logic             core_done,
    input  logic [XLEN-1:0]  core_result,
    input  logic [4:0]       core_flags,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [4:0]       resp_flags,
    output logic [TAG_W-1:0] resp_tag
);

    localparam int AW     = $clog2(DEPTH);
    localparam int ENT_W  = OP_W + 3 + 3 * XLEN + TAG_W;
    localparam int CORE_W = ENT_W - TAG_W;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t             state_q, state_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [ENT_W-1:0]   cur_q, cur_d;
    logic               resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]    resp_result_q, resp_result_d;
    logic [4:0]         resp_flags_q, resp_flags_d;
    logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;

    logic               empty, full, push, pop, bypass, src_vld;
    logic [ENT_W-1:0]   req_ent, head_ent, src_ent;
    logic [CORE_W-1:0]  core_ent;

    // Entry layout, MSB first: op, rm, a, b, c, tag. The tag stays out of the core.
    assign req_ent  = {req_op, req_rm, req_a, req_b, req_c, req_tag};
    assign head_ent = mem_q[rd_ptr_q[AW-1:0]];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign req_ready = !full;
    assign core_op   = core_ent[CORE_W-1 -: OP_W];
    assign core_rm   = core_ent[3*XLEN +: 3];
    assign core_a    = core_ent[2*XLEN +: XLEN];
    assign core_b    = core_ent[XLEN +: XLEN];
    assign core_c    = core_ent[0 +: XLEN];

    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_flags  = resp_flags_q;
    assign resp_tag    = resp_tag_q;

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        resp_tag_d    = resp_tag_q;
        core_start    = 1'b0;
        core_ent      = '0;
        pop           = 1'b0;
        bypass        = 1'b0;
        src_ent       = head_ent;
        src_vld       = !empty;
`ifdef FPU_ISSUE_BYPASS_EN
        if (state_q == IDLE && empty) begin
            src_ent = req_ent;
            src_vld = req_valid;
            bypass  = req_valid;
        end
`else
        bypass = 1'b0;
`endif
        push = req_valid && !full && !bypass;

        case (state_q)
            IDLE: begin
                if (src_vld) begin
                    core_start = 1'b1;
                    core_ent   = src_ent[ENT_W-1:TAG_W];
                    cur_d      = src_ent;
                    pop        = !bypass;
                    // A result can come back in the issue cycle itself.
                    if (core_done) begin
                        resp_valid_d  = 1'b1;
                        resp_result_d = core_result;
                        resp_flags_d  = core_flags;
                        resp_tag_d    = src_ent[TAG_W-1:0];
                        state_d       = HOLD;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                core_ent = cur_q[ENT_W-1:TAG_W];
                if (core_done) begin
                    resp_valid_d  = 1'b1;
                    resp_result_d = core_result;
                    resp_flags_d  = core_flags;
                    resp_tag_d    = cur_q[TAG_W-1:0];
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                core_ent = cur_q[ENT_W-1:TAG_W];
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
            resp_tag_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
            resp_tag_q    <= resp_tag_d;
        end
    end

    // Payload storage carries no reset; it is only read once the control says it is valid.
    always_ff @(posedge clk) begin
        cur_q <= cur_d;
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= req_ent;
        end
    end

endmodule
